// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and port IDs for the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;
endpackage

// File: rtl/main_memory.sv
// rtl/main_memory.sv - 1K-word memory model with registered read data
module main_memory #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data_in,
    input  logic          rd,
    input  logic          wr,
    output logic [DW-1:0] data_out
);
    localparam logic [DW-1:0] INIT_BASE = DW'(32'hC200_2014);

    logic [DW-1:0] mem [1024];
    logic [9:0]    idx;

    assign idx = address[11:2];

    // Reset contents are base + byte address, so every word is predictable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++)
                mem[i] <= INIT_BASE + DW'(i << 2);
            data_out <= '0;
        end else begin
            if (wr)
                mem[idx] <= data_in;
            if (rd)
                data_out <= mem[idx];
        end
    end
endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin selector; req[0]=fetch, req[1]=data
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);
    always_comb begin
        grant = PORT_IF;
        if (req == 2'b11)
            grant = ~last;
        else if (req[1])
            grant = PORT_D;
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory between fetch and data ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_data_out,
    output logic          busy,
    output logic [CW-1:0] if_cnt,
    output logic [CW-1:0] d_cnt
);
    state_t        state;
    logic          last_grant;
    logic          grant;
    logic          port_lat;
    logic          we_lat;
    logic [AW-1:0] addr_lat;
    logic [DW-1:0] wdata_lat;
    logic          rd_q, wr_q, if_ack_q, d_ack_q, busy_q;

    rr_arb2 u_rr_arb2 (
        .req   ({d_req, if_req}),
        .last  (last_grant),
        .grant (grant)
    );

    // Gating with rst kills strobes in the very cycle reset is raised.
    assign mem_rd      = rd_q & ~rst;
    assign mem_wr      = wr_q & ~rst;
    assign if_ack      = if_ack_q & ~rst;
    assign d_ack       = d_ack_q & ~rst;
    assign busy        = busy_q & ~rst;
    assign mem_address = addr_lat;
    assign mem_data_in = wdata_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= PORT_D;
            port_lat   <= PORT_IF;
            we_lat     <= 1'b0;
            addr_lat   <= '0;
            wdata_lat  <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_cnt     <= '0;
            d_cnt      <= '0;
        end else begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        port_lat   <= grant;
                        last_grant <= grant;
                        busy_q     <= 1'b1;
                        state      <= ACCESS;
                        if (grant == PORT_D) begin
                            we_lat    <= d_we;
                            addr_lat  <= d_addr;
                            wdata_lat <= d_wdata;
                            rd_q      <= ~d_we;
                            wr_q      <= d_we;
                        end else begin
                            we_lat    <= 1'b0;
                            addr_lat  <= if_addr;
                            wdata_lat <= '0;
                            rd_q      <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (we_lat) begin
                        state <= DONE;
                        if (port_lat == PORT_D) d_ack_q <= 1'b1;
                        else                    if_ack_q <= 1'b1;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state <= DONE;
                    if (port_lat == PORT_D) begin
                        d_rdata <= mem_data_out;
                        d_ack_q <= 1'b1;
                    end else begin
                        if_rdata <= mem_data_out;
                        if_ack_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (port_lat == PORT_D) begin
                        if (d_cnt != '1) d_cnt <= d_cnt + CW'(1);
                    end else begin
                        if (if_cnt != '1) if_cnt <= if_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter CW, 16, width of per-port access counters.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 if_req, if_addr  in  1, AW  instruction-fetch read request; level signal, held until if_ack.
REQ-007 if_ack, if_rdata  out  1, DW  fetch completion pulse; read data.
REQ-008 d_req, d_we, d_addr, d_wdata  in  1, 1, AW, DW  data-port request; d_we=1 write, 0 read; held until d_ack.
REQ-009 d_ack, d_rdata  out  1, DW  data-port completion pulse; read data.
REQ-010 mem_address, mem_data_in  out  AW, DW  to main memory.
REQ-011 mem_rd, mem_wr  out  1, 1  main memory strobes.
REQ-012 mem_data_out  in  DW  main memory data, registered inside the memory; valid the cycle after a mem_rd edge.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 if_cnt, d_cnt  out  CW, CW  completed-access counters.

Function
REQ-015 The FSM has four states: IDLE, ACCESS, CAPTURE and DONE.
REQ-016 IDLE: at a clock edge with any req high, the block latches the winner's port ID, address, wdata and we (fetch: we=0), and moves to ACCESS; with no request it stays in IDLE.
REQ-017 Arbitration is round-robin: with a single request, that port wins; with both requesting, the port not granted last wins; last_grant updates on every grant.
REQ-018 ACCESS: mem_rd=~we_lat and mem_wr=we_lat for exactly one cycle; next state is DONE if we_lat=1, else CAPTURE.
REQ-019 CAPTURE: mem_data_out is registered into the winner's rdata register; next state is DONE.
REQ-020 DONE: the winner's ack is high for exactly one cycle; next state is IDLE.
REQ-021 Latency from the IDLE edge that samples req to the ack cycle: write 2 cycles, read 3 cycles.
REQ-022 mem_rd and mem_wr are 0 in every state except ACCESS.
REQ-023 mem_address and mem_data_in always drive the latched values.
REQ-024 Requests are not sampled in ACCESS, CAPTURE or DONE.
REQ-025 A req still high in the cycle after DONE (IDLE) is treated as a new request.
REQ-026 if_rdata and d_rdata hold their last captured value until the next read by the same port; a write never changes them.
REQ-027 if_cnt and d_cnt increment on their port's ack and saturate at all-ones.
REQ-028 d_we is ignored for the fetch port; the fetch port never writes.

Reset
REQ-029 While rst is high: state=IDLE, last_grant=DATA (first conflict goes to fetch), and mem_rd, mem_wr, if_ack, d_ack and busy are 0.
REQ-030 While rst is high, latched address/data, rdata registers and counters are all 0.
REQ-031 rst asserted during ACCESS forces mem_wr and mem_rd to 0 in that same cycle; the aborted transaction is never acked.
REQ-032 After reset release, requesters must re-present their requests.

Structure
REQ-033 Package mem_arb_pkg holds the state enum (IDLE, ACCESS, CAPTURE, DONE) and the port-ID constants (PORT_IF=0, PORT_D=1).
REQ-034 Two-way round-robin selection is a sub-module, rr_arb2 (inputs req[1:0] and last; output grant), instantiated once.
REQ-035 Counters and FSM reside in mem_arbiter.

Verification
REQ-036 The bench uses main_memory as the memory model, connected to mem_*.
REQ-037 Scenario: after reset, if_req=1, if_addr=2048 -> if_ack on the 3rd cycle, if_rdata=32'hC2002814, if_cnt=1.
REQ-038 Scenario: d write addr=2064, wdata=32'h55, then d read 2064 -> write d_ack at cycle 2, read d_ack at cycle 3, d_rdata=32'h55, mem_wr high exactly one cycle.
REQ-039 Scenario: if_req and d_req rise on the same edge right after reset -> fetch is served first, data second, no idle gap beyond one IDLE cycle, each ack seen once.
REQ-040 Scenario: both requests held high continuously for 6 transactions -> grants alternate IF, D, IF, D, IF, D.
REQ-041 Scenario: rst asserted during the CAPTURE of a d read of 2052 -> no d_ack, state=IDLE, d_rdata=0, mem_rd=0.
REQ-042 Scenario: preload if_cnt to all-ones minus 1, then perform 3 fetches -> if_cnt saturates at 16'hFFFF.
